// File: rtl/window_stream.sv
// rtl/window_stream.sv - streaming frame windowing stage for the MFCC front end
// Two-stage pipeline: S1 holds sample+coefficient, S2 holds the rounded/saturated product.

module window_stream #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int FRAME_LEN = 306
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     sync_err
);

  localparam int HALF     = (FRAME_LEN + 1) / 2;
  localparam int IDX_W    = $clog2(FRAME_LEN);
  localparam int ADDR_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int COEF_MAX = (1 << (COEF_W - 1)) - 1;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]         HALF_IDX = IDX_W'(HALF);
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(64'sd1 <<< (COEF_W - 2));
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-(64'sd1 <<< (DATA_W - 1)));

  // kind 0 = Hamming, otherwise Hann; evaluated only at elaboration
  function automatic logic signed [COEF_W-1:0] win_coef(input int kind, input int n);
    real pi;
    real a;
    real b;
    real v;
    int  c;
    pi = 3.14159265358979323846;
    if (kind == 0) begin
      a = 0.54;
      b = 0.46;
    end else begin
      a = 0.5;
      b = 0.5;
    end
    v = (a - b * $cos(2.0 * pi * real'(n) / real'(FRAME_LEN - 1))) * (2.0 ** (COEF_W - 1));
    c = $rtoi(v + 0.5);
    if (c > COEF_MAX) c = COEF_MAX;
    if (c < 0) c = 0;
    return COEF_W'(c);
  endfunction

  logic signed [COEF_W-1:0] ham_rom  [HALF];
  logic signed [COEF_W-1:0] hann_rom [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam logic signed [COEF_W-1:0] HAM_C  = win_coef(0, g);
    localparam logic signed [COEF_W-1:0] HANN_C = win_coef(1, g);
    assign ham_rom[g]  = HAM_C;
    assign hann_rom[g] = HANN_C;
  end

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [1:0]               mode_q, mode_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
  logic signed [COEF_W-1:0] s1_coef_q, s1_coef_d;
  logic                     s1_sof_q, s1_sof_d;
  logic                     s1_eof_q, s1_eof_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_sof_q, out_sof_d;
  logic                     out_eof_q, out_eof_d;

  logic                     adv;
  logic                     in_fire;
  logic [IDX_W-1:0]         eff_idx;
  logic [IDX_W-1:0]         rom_addr_full;
  logic [ADDR_W-1:0]        rom_addr;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rnd_prod;
  logic signed [PROD_W-1:0] res;
  logic signed [DATA_W-1:0] sat;

  // Input side: index tracking, mode latch, coefficient lookup, S1 load
  always_comb begin
    adv           = !out_valid_q || out_ready;
    in_ready      = adv || !s1_valid_q;
    in_fire       = in_valid && in_ready;
    eff_idx       = in_sof ? '0 : idx_q;
    sync_err      = in_fire && in_sof && (idx_q != '0);
    rom_addr_full = (eff_idx < HALF_IDX) ? eff_idx : (LAST_IDX - eff_idx);
    rom_addr      = ADDR_W'(rom_addr_full);

    // A frame's first sample already uses the newly latched mode
    mode_d = (in_fire && (eff_idx == '0)) ? mode : mode_q;
    case (mode_d)
      2'd0:    coef = ham_rom[rom_addr];
      2'd1:    coef = hann_rom[rom_addr];
      default: coef = COEF_W'(COEF_MAX);
    endcase

    idx_d = idx_q;
    if (in_fire) begin
      idx_d = (eff_idx == LAST_IDX) ? '0 : eff_idx + 1'b1;
    end

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_coef_d  = s1_coef_q;
    s1_sof_d   = s1_sof_q;
    s1_eof_d   = s1_eof_q;
    if (adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_coef_d  = coef;
      s1_sof_d   = (eff_idx == '0);
      s1_eof_d   = (eff_idx == LAST_IDX);
    end
  end

  // Output side: multiply, round half up, saturate, S2 load
  always_comb begin
    prod     = $signed({{COEF_W{s1_data_q[DATA_W-1]}}, s1_data_q})
             * $signed({{DATA_W{s1_coef_q[COEF_W-1]}}, s1_coef_q});
    rnd_prod = prod + RND_HALF;
    res      = rnd_prod >>> (COEF_W - 1);
    if (res > SAT_MAX) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (res < SAT_MIN) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = res[DATA_W-1:0];
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sat;
        out_sof_d  = s1_sof_q;
        out_eof_d  = s1_eof_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      mode_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_coef_q   <= '0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_coef_q   <= s1_coef_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_window_stream.sv
// tb/tb_window_stream.sv - randomized and directed bench for window_stream
// Expected outputs come from a queue-based model using real-valued window formulas.

module tb_window_stream;

  localparam int  N    = 306;
  localparam int  HALF = (N + 1) / 2;
  localparam real PI   = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               in_sof = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic               out_sof;
  logic               out_eof;
  logic               sync_err;

  window_stream #(.DATA_W(16), .COEF_W(16), .FRAME_LEN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int data;
    bit sof;
    bit eof;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   m_idx = 0;
  int   m_mode = 0;
  int   cyc_n = 0;
  bit   lat_chk = 1'b0;
  bit   last_in_fire = 1'b0;
  int   sync_cnt = 0;
  int   cap_data[$];
  bit   cap_sof[$];
  bit   cap_eof[$];
  bit   prev_stall = 1'b0;
  int   prev_data = 0;
  bit   prev_sof = 1'b0;
  bit   prev_eof = 1'b0;

  function automatic int ref_coef(input int m, input int n);
    int  a;
    real w;
    int  c;
    a = (n < HALF) ? n : (N - 1 - n);
    if (m >= 2) return 32767;
    if (m == 0) w = 0.54 - 0.46 * $cos(2.0 * PI * real'(a) / real'(N - 1));
    else        w = 0.5 - 0.5 * $cos(2.0 * PI * real'(a) / real'(N - 1));
    c = $rtoi($floor(w * 32768.0 + 0.5));
    if (c > 32767) c = 32767;
    if (c < 0) c = 0;
    return c;
  endfunction

  function automatic int ref_out(input int x, input int c);
    int r;
    r = $rtoi($floor(real'(x) * real'(c) / 32768.0 + 0.5));
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic clear_caps();
    cap_data = {};
    cap_sof  = {};
    cap_eof  = {};
  endtask

  task automatic cyc(input bit v, input int d, input bit sof, input int m, input bit ordy);
    bit   in_fire;
    bit   out_fire;
    bit   es;
    int   eff;
    exp_t e;
    in_valid  = v;
    in_data   = 16'(d);
    in_sof    = sof;
    mode      = 2'(m);
    out_ready = ordy;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    last_in_fire = in_fire;
    if (prev_stall) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), prev_data);
      chk("hold_sof", int'(out_sof), int'(prev_sof));
      chk("hold_eof", int'(out_eof), int'(prev_eof));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = int'(out_data);
    prev_sof   = out_sof;
    prev_eof   = out_eof;
    es = in_fire && in_sof && (m_idx != 0);
    chk("sync_err", int'(sync_err), int'(es));
    if (sync_err) sync_cnt++;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", int'(out_fire), 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_sof", int'(out_sof), int'(e.sof));
        chk("out_eof", int'(out_eof), int'(e.eof));
        if (lat_chk) chk("latency", cyc_n - e.acc_cyc, 2);
      end
      cap_data.push_back(int'(out_data));
      cap_sof.push_back(out_sof);
      cap_eof.push_back(out_eof);
    end
    if (in_fire) begin
      eff = in_sof ? 0 : m_idx;
      if (eff == 0) m_mode = int'(mode);
      e.data    = ref_out(int'(in_data), ref_coef(m_mode, eff));
      e.sof     = (eff == 0);
      e.eof     = (eff == N - 1);
      e.acc_cyc = cyc_n;
      exp_q.push_back(e);
      m_idx = (eff + 1) % N;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int pos;
    int r;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Hamming, continuous flow
    lat_chk = 1'b1;
    clear_caps();
    for (int i = 0; i < N; i++) cyc(1'b1, 10000, i == 0, 0, 1'b1);
    drain(4);
    lat_chk = 1'b0;
    chk("ham_count", cap_data.size(), N);
    if (cap_data.size() == N) begin
      chk("ham_out0", cap_data[0], 800);
      chk("ham_sof0", int'(cap_sof[0]), 1);
      chk("ham_out153", cap_data[153], ref_out(10000, ref_coef(0, 153)));
      chk("ham_out305", cap_data[305], 800);
      chk("ham_eof305", int'(cap_eof[305]), 1);
    end

    // Hann frame, then a mid-frame switch to rectangular that must wait for index 0
    clear_caps();
    for (int i = 0; i < N; i++) cyc(1'b1, -20000, i == 0, 1, 1'b1);
    for (int i = 0; i < N; i++) cyc(1'b1, -20000, 1'b0, (i < 100) ? 1 : 2, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, -20000, 1'b0, 2, 1'b1);
    drain(4);
    chk("hann_count", cap_data.size(), 2 * N + 5);
    if (cap_data.size() == 2 * N + 5) begin
      chk("hann_out0", cap_data[0], 0);
      chk("hann_out305", cap_data[305], 0);
      chk("hann_f2_200", cap_data[N + 200], ref_out(-20000, ref_coef(1, 200)));
      chk("rect_f3_0", cap_data[2 * N], -19999);
    end

    // Rectangular extremes
    clear_caps();
    cyc(1'b1, -32768, 1'b1, 2, 1'b1);
    cyc(1'b1, 32767, 1'b0, 2, 1'b1);
    drain(4);
    chk("rect_count", cap_data.size(), 2);
    if (cap_data.size() == 2) begin
      chk("rect_min", cap_data[0], -32767);
      chk("rect_max", cap_data[1], 32766);
    end

    // Backpressure from an empty pipeline: two accepts then in_ready drops
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 2, 1'b0);
      if (last_in_fire) acc++;
    end
    chk("bp_accepts", acc, 2);
    @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) cyc(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 1'b1);
    drain(4);
    chk("bp_drained", exp_q.size(), 0);

    // Resync: in_sof at index 100
    cyc(1'b1, 10000, 1'b1, 0, 1'b1);
    for (int i = 0; i < 99; i++) cyc(1'b1, 10000, 1'b0, 0, 1'b1);
    drain(4);
    clear_caps();
    sync_cnt = 0;
    cyc(1'b1, 10000, 1'b1, 0, 1'b1);
    for (int i = 0; i < 310; i++) cyc(1'b1, 10000, 1'b0, 0, 1'b1);
    drain(4);
    chk("resync_pulses", sync_cnt, 1);
    chk("resync_count", cap_data.size(), 311);
    if (cap_data.size() == 311) begin
      chk("resync_sof", int'(cap_sof[0]), 1);
      chk("resync_data", cap_data[0], ref_out(10000, 2621));
      pos = -1;
      for (int i = 0; i < cap_eof.size(); i++) begin
        if (cap_eof[i] && pos < 0) pos = i;
      end
      chk("resync_eof_pos", pos, 305);
    end

    // Reset mid-frame with the pipeline full
    cyc(1'b1, 10000, 1'b1, 0, 1'b1);
    for (int i = 0; i < 50; i++) cyc(1'b1, 10000 + i, 1'b0, 0, 1'b1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_sof", int'(out_sof), 0);
    chk("mid_rst_eof", int'(out_eof), 0);
    chk("mid_rst_sync", int'(sync_err), 0);
    exp_q.delete();
    m_idx = 0;
    m_mode = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_caps();
    cyc(1'b1, 777, 1'b0, 2, 1'b1);
    drain(4);
    chk("post_rst_count", cap_data.size(), 1);
    if (cap_data.size() == 1) begin
      chk("post_rst_sof", int'(cap_sof[0]), 1);
      chk("post_rst_data", cap_data[0], 777);
    end

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 15);
      cyc($urandom_range(0, 3) != 0,
          (r == 0) ? -32768 : (r == 1) ? 32767 : int'($urandom_range(0, 65535)) - 32768,
          $urandom_range(0, 199) == 0,
          int'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0);
    end
    drain(6);
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
